// File: rtl/ecc_pkg.sv
// Shared types and width constants for the extended-Hamming encoder and its control sequencer.
package ecc_pkg;

  typedef enum logic [1:0] {
    MODE_8_4,
    MODE_16_11,
    MODE_32_26,
    MODE_ILLEGAL
  } ecc_mode_t;

  typedef enum logic {
    ST_RUN,
    ST_DRAIN
  } ecc_ctrl_state_t;

  localparam int MAX_CODEWORD_WIDTH = 32;
  localparam int MAX_INFO_WIDTH     = 26;

  // Parity width includes the overall-parity bit added by the second stage.
  localparam int INFO_W_8_4    = 4;
  localparam int PAR_W_8_4     = 4;
  localparam int INFO_W_16_11  = 11;
  localparam int PAR_W_16_11   = 5;
  localparam int INFO_W_32_26  = 26;
  localparam int PAR_W_32_26   = 6;

  function automatic logic mode_is_legal(input logic [1:0] mode);
    return mode != MODE_ILLEGAL;
  endfunction

endpackage

// File: rtl/ecc_vld_pipe.sv
// Valid-bit shift register tracking occupancy of the encoder stages; bit 0 is the input side.
module ecc_vld_pipe #(
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               din,
  output logic [LATENCY-1:0] vld
);

  generate
    if (LATENCY == 1) begin : g_single
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld <= '0;
        end else if (en) begin
          vld <= din;
        end
      end
    end else begin : g_multi
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          vld <= '0;
        end else if (en) begin
          vld <= {vld[LATENCY-2:0], din};
        end
      end
    end
  endgenerate

endmodule

// File: rtl/ecc_enc_ctrl.sv
// Control sequencer for the two-stage extended-Hamming encoder: handshake, stage enable, mode switching.
// Optional delivered-codeword counter on port word_cnt is built only when ENC_CTRL_STATS_EN is defined.
//
//   state    | meaning
//   ---------+-------------------------------------------------------------
//   ST_RUN   | accepting words whose mode matches work_mod (or illegal ones to drop)
//   ST_DRAIN | new mode requested; input blocked until every stage is empty
module ecc_enc_ctrl
  import ecc_pkg::*;
#(
  parameter int LATENCY   = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [1:0]           in_mode,
  output logic                 in_ready,
  output logic                 stage_en,
  output logic [1:0]           work_mod,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 busy,
  output logic                 err_mode
`ifdef ENC_CTRL_STATS_EN
  ,
  output logic [CNT_WIDTH-1:0] word_cnt
`endif
);

  generate
    if (LATENCY < 1 || CNT_WIDTH < 1) begin : g_param_check
      $error("ecc_enc_ctrl: LATENCY and CNT_WIDTH must both be at least 1");
    end
  endgenerate

  ecc_ctrl_state_t    state, state_nxt;
  logic [1:0]         mode_nxt;
  logic [LATENCY-1:0] vld;
  logic               pipe_empty;
  logic               mode_legal;
  logic               mode_hit;
  logic               acc;
  logic               vld_in;

  assign out_valid  = vld[LATENCY-1];
  assign stage_en   = !out_valid || out_ready;
  assign pipe_empty = ~|vld;
  assign mode_legal = mode_is_legal(in_mode);
  assign mode_hit   = in_mode == work_mod;
  assign acc        = in_valid && in_ready;
  // Illegal words complete the handshake but never occupy a stage.
  assign vld_in     = acc && mode_legal;
  assign busy       = !pipe_empty || state == ST_DRAIN;

  ecc_vld_pipe #(
    .LATENCY(LATENCY)
  ) u_vld_pipe (
    .clk(clk),
    .rst(rst),
    .en (stage_en),
    .din(vld_in),
    .vld(vld)
  );

  always_comb begin
    state_nxt = state;
    mode_nxt  = work_mod;
    in_ready  = 1'b0;
    case (state)
      ST_RUN: begin
        in_ready = stage_en;
        if (in_valid && mode_legal && !mode_hit) begin
          // A word for a different H matrix is held off until the pipeline is empty.
          in_ready = 1'b0;
          if (pipe_empty) begin
            mode_nxt = in_mode;
          end else begin
            state_nxt = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (!in_valid) begin
          state_nxt = ST_RUN;
        end else if (pipe_empty) begin
          state_nxt = ST_RUN;
          if (mode_legal) begin
            mode_nxt = in_mode;
          end
        end
      end
      default: state_nxt = ST_RUN;
    endcase
    if (!rst) begin
      in_ready = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_RUN;
      work_mod <= MODE_8_4;
      err_mode <= 1'b0;
    end else begin
      state    <= state_nxt;
      work_mod <= mode_nxt;
      err_mode <= acc && !mode_legal;
    end
  end

`ifdef ENC_CTRL_STATS_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      word_cnt <= '0;
    end else if (out_valid && out_ready) begin
      word_cnt <= word_cnt + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_ecc_enc_ctrl.sv
// Self-checking bench for ecc_enc_ctrl: cycle table, scoreboard of accepted words, reset and wrap sequences.
module tb_ecc_enc_ctrl;

  localparam int LAT = 2;
  localparam int CW  = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] in_mode = 2'd0;
  logic       out_ready = 1'b0;
  logic       in_ready, stage_en, out_valid, busy, err_mode;
  logic [1:0] work_mod;
`ifdef ENC_CTRL_STATS_EN
  logic [CW-1:0] word_cnt;
`endif

  int checks = 0;
  int errors = 0;
  int delivered = 0;
  int cyc = 0;
  bit exact_lat = 1'b0;

  typedef struct {
    logic [1:0] mode;
    int         cyc;
  } sb_t;
  sb_t sb[$];

  typedef struct {
    logic       iv;
    logic [1:0] md;
    logic       ordy;
    logic       ir;
    logic       ov;
    logic       bz;
    logic       er;
    logic [1:0] wm;
  } vec_t;
  vec_t tbl[30];

  ecc_enc_ctrl #(
    .LATENCY  (LAT),
    .CNT_WIDTH(CW)
  ) dut (
    .clk      (clk),
    .rst      (rst_n),
    .in_valid (in_valid),
    .in_mode  (in_mode),
    .in_ready (in_ready),
    .stage_en (stage_en),
    .work_mod (work_mod),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .busy     (busy),
    .err_mode (err_mode)
`ifdef ENC_CTRL_STATS_EN
    ,
    .word_cnt (word_cnt)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic vec_t v(input int iv, input int md, input int ordy, input int ir,
                             input int ov, input int bz, input int er, input int wm);
    vec_t t;
    t.iv = iv[0]; t.md = md[1:0]; t.ordy = ordy[0];
    t.ir = ir[0]; t.ov = ov[0]; t.bz = bz[0]; t.er = er[0]; t.wm = wm[1:0];
    return t;
  endfunction

  // Scoreboard: legal accepted words are queued; every output handshake must match one in order.
  always @(negedge clk) begin
    sb_t e;
    if (!rst_n) begin
      sb.delete();
    end else begin
      if (in_valid && in_ready && in_mode != 2'b11) begin
        e.mode = in_mode;
        e.cyc  = cyc;
        sb.push_back(e);
      end
      if (out_valid && out_ready) begin
        chk("sb_word_expected", sb.size() != 0, 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          delivered++;
          chk("out_mode", work_mod, e.mode);
          if (exact_lat) chk("latency", cyc - e.cyc, LAT);
          else chk("latency_min", (cyc - e.cyc) >= LAT, 1);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    //          iv md or  ir ov bz er wm
    tbl[0]  = v(1, 0, 1,  1, 0, 0, 0, 0);
    tbl[1]  = v(1, 0, 1,  1, 0, 1, 0, 0);
    tbl[2]  = v(1, 0, 1,  1, 1, 1, 0, 0);
    tbl[3]  = v(0, 0, 1,  1, 1, 1, 0, 0);
    tbl[4]  = v(0, 0, 1,  1, 1, 1, 0, 0);
    tbl[5]  = v(0, 0, 1,  1, 0, 0, 0, 0);
    tbl[6]  = v(1, 0, 0,  1, 0, 0, 0, 0);
    tbl[7]  = v(1, 0, 0,  1, 0, 1, 0, 0);
    tbl[8]  = v(1, 0, 0,  0, 1, 1, 0, 0);
    tbl[9]  = v(1, 0, 0,  0, 1, 1, 0, 0);
    tbl[10] = v(1, 0, 1,  1, 1, 1, 0, 0);
    tbl[11] = v(0, 0, 1,  1, 1, 1, 0, 0);
    tbl[12] = v(0, 0, 1,  1, 1, 1, 0, 0);
    tbl[13] = v(0, 0, 1,  1, 0, 0, 0, 0);
    tbl[14] = v(1, 0, 1,  1, 0, 0, 0, 0);
    tbl[15] = v(1, 2, 1,  0, 0, 1, 0, 0);
    tbl[16] = v(1, 2, 1,  0, 1, 1, 0, 0);
    tbl[17] = v(1, 2, 1,  0, 0, 1, 0, 0);
    tbl[18] = v(1, 2, 1,  1, 0, 0, 0, 2);
    tbl[19] = v(0, 0, 1,  1, 0, 1, 0, 2);
    tbl[20] = v(0, 0, 1,  1, 1, 1, 0, 2);
    tbl[21] = v(1, 1, 1,  0, 0, 0, 0, 2);
    tbl[22] = v(1, 1, 1,  1, 0, 0, 0, 1);
    tbl[23] = v(1, 3, 1,  1, 0, 1, 0, 1);
    tbl[24] = v(0, 0, 1,  1, 1, 1, 1, 1);
    tbl[25] = v(0, 0, 1,  1, 0, 0, 0, 1);
    tbl[26] = v(1, 1, 1,  1, 0, 0, 0, 1);
    tbl[27] = v(1, 0, 1,  0, 0, 1, 0, 1);
    tbl[28] = v(0, 0, 1,  0, 1, 1, 0, 1);
    tbl[29] = v(0, 0, 1,  1, 0, 0, 0, 1);

    // Reset state, with stage_en high so in_ready must be held low by reset alone.
    out_ready = 1'b1;
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_work_mod", work_mod, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_mode", err_mode, 0);
`ifdef ENC_CTRL_STATS_EN
    chk("rst_word_cnt", word_cnt, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      in_valid  = tbl[i].iv;
      in_mode   = tbl[i].md;
      out_ready = tbl[i].ordy;
      @(negedge clk);
      chk($sformatf("row%0d_in_ready", i), in_ready, tbl[i].ir);
      chk($sformatf("row%0d_out_valid", i), out_valid, tbl[i].ov);
      chk($sformatf("row%0d_busy", i), busy, tbl[i].bz);
      chk($sformatf("row%0d_err_mode", i), err_mode, tbl[i].er);
      chk($sformatf("row%0d_work_mod", i), work_mod, tbl[i].wm);
      chk($sformatf("row%0d_stage_en", i), stage_en, !tbl[i].ov || tbl[i].ordy);
    end
    chk("table_delivered", delivered, 10);
`ifdef ENC_CTRL_STATS_EN
    chk("table_word_cnt", word_cnt, 10);
`endif

    // Two mode-01 words in flight, then asynchronous reset between edges.
    @(posedge clk); #1; in_valid = 1'b1; in_mode = 2'd1; out_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(negedge clk);
    chk("pre_rst_out_valid", out_valid, 1);
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_work_mod", work_mod, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    chk("mid_rst_busy", busy, 0);
`ifdef ENC_CTRL_STATS_EN
    chk("mid_rst_word_cnt", word_cnt, 0);
`endif
    @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    base = delivered;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("post_rst_out_valid%0d", i), out_valid, 0);
      chk($sformatf("post_rst_err_mode%0d", i), err_mode, 0);
    end
    chk("post_rst_delivered", delivered - base, 0);

    // 17 back-to-back mode-00 words with exact latency; the 4-bit counter wraps to 1.
    exact_lat = 1'b1;
    base = delivered;
    for (int i = 0; i < 17; i++) begin
      @(posedge clk); #1; in_valid = 1'b1; in_mode = 2'd0; out_ready = 1'b1;
      @(negedge clk);
      chk($sformatf("burst_in_ready%0d", i), in_ready, 1);
    end
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("burst_delivered", delivered - base, 17);
    chk("burst_sb_empty", sb.size(), 0);
    chk("burst_work_mod", work_mod, 0);
    chk("burst_busy", busy, 0);
`ifdef ENC_CTRL_STATS_EN
    chk("burst_word_cnt", word_cnt, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ecc_enc_ctrl.md
# ecc_enc_ctrl

Control sequencer for the two-stage extended-Hamming encoder pipeline (parity stage, then overall-parity stage). It accepts info words through a valid/ready handshake and tracks the valid bit of every pipeline stage. It drives a common stage enable and presents the work mode to the datapath. Mode changes only take effect after the pipeline has drained, so no in-flight word is encoded with the wrong H matrix.

## Interface
Parameters:
- LATENCY, 2, number of registered encoder stages (≥1)
- CNT_WIDTH, 16, width of the statistics counter

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-low reset
- in_valid  in  1  upstream word available
- in_mode  in  2  work mode of the offered word: 00 = (8,4), 01 = (16,11), 10 = (32,26), 11 = illegal
- in_ready  out  1  controller accepts word this cycle
- stage_en  out  1  load enable for every encoder stage register
- work_mod  out  2  mode applied to the encoder datapath
- out_valid  out  1  last stage holds a valid codeword
- out_ready  in  1  downstream accepts codeword
- busy  out  1  any stage valid, or state ≠ RUN
- err_mode  out  1  one-cycle pulse when an illegal-mode word is dropped
- word_cnt  out  CNT_WIDTH  codewords delivered (only with ENC_CTRL_STATS_EN)

## Operation
- Valid shift register `vld[LATENCY-1:0]`. Stage 0 is the input side. `out_valid = vld[LATENCY-1]`.
- `stage_en = !out_valid || out_ready`. The whole pipeline advances together or stalls together; there are no bubbles squeezed out.
- Accept condition: `acc = in_valid && in_ready`. When `stage_en` is high, `vld` shifts and `vld[0] <= acc && in_mode != 2'b11`.
- FSM states:
  - RUN: `in_ready = stage_en`.
    - `in_valid` with legal `in_mode == work_mod` → accept.
    - `in_valid` with legal `in_mode != work_mod`: if the pipeline is empty, `work_mod <= in_mode` and no accept this cycle. Otherwise go to DRAIN, still with no accept.
    - `in_mode == 11` → accept, drop the word, pulse `err_mode` the next cycle.
  - DRAIN: `in_ready = 0`. Stages keep advancing under `stage_en`. When all `vld` are 0, `work_mod <= in_mode` and go to RUN. If `in_valid` fell meanwhile, return to RUN with `work_mod` unchanged.
- The accepted word is encoded with the `work_mod` value current in its accept cycle. `work_mod` never changes while any `vld` bit is set.
- `busy = |vld || state == DRAIN`.

## Timing
- Reset values:
  - `vld = 0`, `out_valid = 0`, `in_ready = 0` during reset.
  - `work_mod = 2'b00`, `err_mode = 0`, `busy = 0`, `word_cnt = 0`.
  - State = RUN.
- First cycle after reset release: `in_ready = 1`.
- Latency: a word accepted in cycle n has `out_valid` high in cycle n+LATENCY when there are no stalls. Throughput is 1 word/cycle.
- Backpressure: `out_valid` and codeword stay stable while `out_ready = 0`. `in_ready` drops combinationally in the same cycle.
- Simultaneous output handshake and input accept while full → both occur, and occupancy is unchanged.
- Mode-switch cost: the drain time plus 1 cycle for the `work_mod` update before the new word is accepted.
- Asynchronous reset mid-operation discards all in-flight words and does not emit `err_mode`.

## Configuration
- `ENC_CTRL_STATS_EN` defined:
  - `word_cnt` increments on every `out_valid && out_ready`.
  - Wraps from all-ones to 0.
  - Dropped illegal words are not counted.
- Undefined: the `word_cnt` port and counter are absent. All other behaviour is identical.

## Structure
- Shared package `ecc_pkg`:
  - `typedef enum logic [1:0] {MODE_8_4, MODE_16_11, MODE_32_26, MODE_ILLEGAL} ecc_mode_t;`
  - Width constants: MAX_CODEWORD_WIDTH = 32, MAX_INFO_WIDTH = 26, per-mode info and parity widths.
  - FSM state enum `ecc_ctrl_state_t`.
- One sub-module: `ecc_vld_pipe`, the LATENCY-deep valid shift register with a common enable.

## Test plan
- Reset, then 5 back-to-back mode-00 words with `out_ready = 1`: `out_valid` is high in cycles 2–6 after the first accept, `work_mod` stays 00, `word_cnt` = 5.
- `out_ready` held 0 for 4 cycles with the pipeline full: `in_ready = 0` and `out_valid` stays 1 throughout; after release, no word is lost or duplicated.
- Mode-00 word, then a mode-10 word offered the next cycle:
  - DRAIN is entered and `in_ready` stays 0 until `vld = 0`.
  - `work_mod` becomes 10 only after the mode-00 codeword leaves.
  - The mode-10 word is then accepted.
- `in_mode = 11` offered: the word is accepted, `err_mode` pulses once, no `out_valid` results from it, `word_cnt` is unchanged.
- Reset asserted while 2 words are in flight:
  - `out_valid` goes to 0 immediately and `work_mod` to 00.
  - After release, neither word appears.
- Build with `ENC_CTRL_STATS_EN` and CNT_WIDTH = 4, deliver 17 codewords: `word_cnt` = 1.
